// File: rtl/pgs_tsmac_apb_host_bridge_v1_1.sv
// APB slave to multi-channel host-register bridge for TSMAC/PHY register banks.
// Optional access timeout enabled by defining TSMAC_APB_TIMEOUT_EN.
module pgs_tsmac_apb_host_bridge_v1_1 #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 32,
    parameter int unsigned CH_SEL_LSB = 12,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                 pclk,
    input  logic                 prst,
    input  logic [AW-1:0]        paddr,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [DW-1:0]        pwdata,
    output logic [DW-1:0]        prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [NUM_CH-1:0]    hstcsn,
    output logic                 hstwrn,
    output logic [AW-1:0]        hstaddr,
    output logic [DW-1:0]        hstwdata,
    input  logic [NUM_CH*DW-1:0] hstrdata,
    input  logic [NUM_CH-1:0]    hstack
);

    localparam int unsigned CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CHW1 = CHW + 1;

    // Reject configurations the decode and timeout logic cannot represent.
    if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("pgs_tsmac_apb_host_bridge_v1_1: NUM_CH must be 1..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic                wr_q, wr_d;
    logic [DW-1:0]       prdata_d;
    logic                pready_d;
    logic                pslverr_d;
    logic [NUM_CH-1:0]   hstcsn_d;
    logic                hstwrn_d;
    logic [AW-1:0]       hstaddr_d;
    logic [DW-1:0]       hstwdata_d;

    logic [CHW-1:0]      ch_in;
    logic                ch_ok;
    logic                ack_sel;
    logic [DW-1:0]       rd_sel;
    logic                timeout_hit;

    assign ch_in = paddr[CH_SEL_LSB +: CHW];
    assign ch_ok = ({1'b0, ch_in} < CHW1'(NUM_CH));

    // Only the addressed channel's ack and read data are visible to the FSM.
    always_comb begin
        ack_sel = 1'b0;
        rd_sel  = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (ch_q == CHW'(i)) begin
                ack_sel = hstack[i];
                rd_sel  = hstrdata[i*DW +: DW];
            end
        end
    end

`ifdef TSMAC_APB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Counts ACCESS cycles; cleared on every ACCESS entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (state_q == S_ACCESS) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        wr_d       = wr_q;
        prdata_d   = prdata;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        hstcsn_d   = hstcsn;
        hstwrn_d   = hstwrn;
        hstaddr_d  = hstaddr;
        hstwdata_d = hstwdata;

        unique case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    ch_d = ch_in;
                    wr_d = pwrite;
                    if (ch_ok) begin
                        hstaddr_d  = paddr;
                        hstwdata_d = pwdata;
                        hstcsn_d   = ~(NUM_CH'(1) << ch_in);
                        hstwrn_d   = ~pwrite;
                        state_d    = S_ACCESS;
                    end else begin
                        prdata_d  = '0;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_ACCESS: begin
                if (!psel) begin
                    hstcsn_d = '1;
                    hstwrn_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (ack_sel) begin
                    hstcsn_d = '1;
                    hstwrn_d = 1'b1;
                    if (!wr_q) begin
                        prdata_d = rd_sel;
                    end
                    pready_d = 1'b1;
                    state_d  = S_DONE;
                end else if (timeout_hit) begin
                    hstcsn_d  = '1;
                    hstwrn_d  = 1'b1;
                    prdata_d  = '0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                hstcsn_d = '1;
                hstwrn_d = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            wr_q     <= 1'b0;
            prdata   <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            hstcsn   <= '1;
            hstwrn   <= 1'b1;
            hstaddr  <= '0;
            hstwdata <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            wr_q     <= wr_d;
            prdata   <= prdata_d;
            pready   <= pready_d;
            pslverr  <= pslverr_d;
            hstcsn   <= hstcsn_d;
            hstwrn   <= hstwrn_d;
            hstaddr  <= hstaddr_d;
            hstwdata <= hstwdata_d;
        end
    end

endmodule
